// File: rtl/seq_det_pkg.sv
// Shared elaboration helpers for the sequence detector: state width and
// KMP-based transition computation over an MSB-first pattern.
package seq_det_pkg;

    localparam int unsigned MAX_SEQ_LEN = 16;

    // Bits needed to encode S0..S(seq_len).
    function automatic int unsigned state_width(input int unsigned seq_len);
        return $clog2(seq_len + 1);
    endfunction

    // Pattern bit i, counted from the first received bit (the MSB).
    function automatic logic pat_bit(input logic [MAX_SEQ_LEN-1:0] pat,
                                     input int unsigned len,
                                     input int unsigned i);
        logic [MAX_SEQ_LEN-1:0] sh;
        sh = pat >> (len - 1 - i);
        return sh[0];
    endfunction

    // Longest proper prefix of the whole pattern that is also its suffix.
    function automatic int unsigned seq_fail(input logic [MAX_SEQ_LEN-1:0] pat,
                                             input int unsigned len);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned j = 1; j < len; j++) begin
            ok = 1'b1;
            for (int unsigned i = 0; i < j; i++) begin
                if (pat_bit(pat, len, i) != pat_bit(pat, len, len - j + i)) ok = 1'b0;
            end
            if (ok) best = j;
        end
        return best;
    endfunction

    // Next state from Sk (k < len) on bit b: longest pattern prefix that is a
    // suffix of the k matched bits followed by b (covers both advance and fall-back).
    function automatic int unsigned seq_next(input logic [MAX_SEQ_LEN-1:0] pat,
                                             input int unsigned len,
                                             input int unsigned k,
                                             input logic b);
        int unsigned best;
        int unsigned p;
        logic        ok;
        logic        tb;
        best = 0;
        for (int unsigned j = 1; j <= k + 1; j++) begin
            if (j <= len) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < j; i++) begin
                    p  = k + 1 - j + i;
                    tb = (p == k) ? b : pat_bit(pat, len, p);
                    if (tb != pat_bit(pat, len, i)) ok = 1'b0;
                end
                if (ok) best = j;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating detection counter with synchronous clear.
module seq_match_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    // Count detections, sticking at all-ones; clear wins over inc.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/moore_seq_detector.sv
// Moore serial pattern detector with selectable overlapping detection and a
// saturating match counter. Transitions are derived from PATTERN at elaboration.
module moore_seq_detector
    import seq_det_pkg::*;
#(
    parameter int unsigned         SEQ_LEN = 3,
    parameter logic [SEQ_LEN-1:0]  PATTERN = 3'b101,
    parameter int unsigned         CNT_W   = 8,
    localparam int unsigned        SW      = state_width(SEQ_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in,
    input  logic             in_valid,
    input  logic             overlap,
    input  logic             clear,
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic [SW-1:0]    state
);

    localparam logic [MAX_SEQ_LEN-1:0] PAT16    = MAX_SEQ_LEN'(PATTERN);
    localparam int unsigned            N_ROWS   = 1 << SW;
    localparam logic [SW-1:0]          MATCH_ST = SW'(SEQ_LEN);
    localparam int unsigned            FAIL_K   = seq_fail(PAT16, SEQ_LEN);

    // Exits from MATCH: restart from the failure state or from S0.
    localparam logic [SW-1:0] M_OV0 = SW'(seq_next(PAT16, SEQ_LEN, FAIL_K, 1'b0));
    localparam logic [SW-1:0] M_OV1 = SW'(seq_next(PAT16, SEQ_LEN, FAIL_K, 1'b1));
    localparam logic [SW-1:0] M_NO0 = SW'(seq_next(PAT16, SEQ_LEN, 0, 1'b0));
    localparam logic [SW-1:0] M_NO1 = SW'(seq_next(PAT16, SEQ_LEN, 0, 1'b1));

    logic [SW-1:0] nxt0 [N_ROWS];
    logic [SW-1:0] nxt1 [N_ROWS];
    logic [SW-1:0] state_nxt;
    logic          hit;

    // Constant transition table for S0..S(SEQ_LEN-1); unused codes padded to S0.
    for (genvar k = 0; k < N_ROWS; k++) begin : g_row
        if (k < SEQ_LEN) begin : g_live
            localparam int unsigned N0 = seq_next(PAT16, SEQ_LEN, k, 1'b0);
            localparam int unsigned N1 = seq_next(PAT16, SEQ_LEN, k, 1'b1);
            assign nxt0[k] = SW'(N0);
            assign nxt1[k] = SW'(N1);
        end else begin : g_pad
            assign nxt0[k] = '0;
            assign nxt1[k] = '0;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= '0;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection; overlap only matters when leaving MATCH.
    always_comb begin
        state_nxt = state;
        hit       = 1'b0;
        if (clear) begin
            state_nxt = '0;
        end else if (in_valid) begin
            if (state == MATCH_ST) begin
                if (overlap) state_nxt = in ? M_OV1 : M_OV0;
                else         state_nxt = in ? M_NO1 : M_NO0;
            end else begin
                state_nxt = in ? nxt1[state] : nxt0[state];
            end
            hit = (state_nxt == MATCH_ST);
        end
    end

    assign out = (state == MATCH_ST);

    seq_match_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (hit),
        .clear (clear),
        .count (match_count)
    );

endmodule

// File: tb/tb_moore_seq_detector.sv
// Randomized and directed bench for moore_seq_detector. Three instances share
// one stimulus stream: default pattern, a 2-bit counter, and a 4-bit pattern.
module tb_moore_seq_detector;

    logic clk;
    logic reset;
    logic in;
    logic in_valid;
    logic overlap;
    logic clear;

    logic       a_out, b_out, c_out;
    logic [7:0] a_cnt, c_cnt;
    logic [1:0] b_cnt;
    logic [1:0] a_st, b_st;
    logic [2:0] c_st;

    int tests = 0;
    int errs  = 0;

    moore_seq_detector u_a (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
        .clear(clear), .out(a_out), .match_count(a_cnt), .state(a_st)
    );

    moore_seq_detector #(.CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
        .clear(clear), .out(b_out), .match_count(b_cnt), .state(b_st)
    );

    moore_seq_detector #(.SEQ_LEN(4), .PATTERN(4'b1101)) u_c (
        .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
        .clear(clear), .out(c_out), .match_count(c_cnt), .state(c_st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the history of consumed bits since the last restart.
    typedef struct {
        logic [31:0] hist;
        int          len;
        logic        hit;
        int          cnt;
    } mdl_t;

    mdl_t ma, mb, mc;

    function automatic mdl_t mdl_clear();
        mdl_t m;
        m.hist = '0;
        m.len  = 0;
        m.hit  = 1'b0;
        m.cnt  = 0;
        return m;
    endfunction

    // A detection is the last plen history bits equal to the pattern; in
    // non-overlap mode the history restarts after a detection.
    function automatic mdl_t mdl_step(mdl_t m, logic b, logic ovl, int plen,
                                      logic [31:0] pat, int cmax);
        logic [31:0] mask;
        mdl_t        r;
        r = m;
        if (r.hit && !ovl) begin
            r.hist = '0;
            r.len  = 0;
        end
        r.hist = {r.hist[30:0], b};
        if (r.len < 32) r.len = r.len + 1;
        mask  = (32'(1) << plen) - 32'(1);
        r.hit = (r.len >= plen) && ((r.hist & mask) == (pat & mask));
        if (r.hit && r.cnt < cmax) r.cnt = r.cnt + 1;
        return r;
    endfunction

    // Expected state: longest pattern prefix ending the history.
    function automatic int mdl_state(mdl_t m, int plen, logic [31:0] pat);
        logic [31:0] mask;
        for (int j = plen; j > 0; j--) begin
            mask = (32'(1) << j) - 32'(1);
            if (j <= m.len && ((m.hist & mask) == (pat >> (plen - j)))) return j;
        end
        return 0;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a_out"}, int'(a_out), int'(ma.hit));
        chk({tag, "_a_st"},  int'(a_st),  mdl_state(ma, 3, 32'b101));
        chk({tag, "_a_cnt"}, int'(a_cnt), ma.cnt);
        chk({tag, "_b_out"}, int'(b_out), int'(mb.hit));
        chk({tag, "_b_st"},  int'(b_st),  mdl_state(mb, 3, 32'b101));
        chk({tag, "_b_cnt"}, int'(b_cnt), mb.cnt);
        chk({tag, "_c_out"}, int'(c_out), int'(mc.hit));
        chk({tag, "_c_st"},  int'(c_st),  mdl_state(mc, 4, 32'b1101));
        chk({tag, "_c_cnt"}, int'(c_cnt), mc.cnt);
    endtask

    // One clock: drive on the falling edge, check just after the rising edge.
    task automatic cyc(input string tag, input logic b, input logic v,
                       input logic ovl, input logic clr);
        @(negedge clk);
        in       = b;
        in_valid = v;
        overlap  = ovl;
        clear    = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            ma = mdl_clear();
            mb = mdl_clear();
            mc = mdl_clear();
        end else if (v) begin
            ma = mdl_step(ma, b, ovl, 3, 32'b101, 255);
            mb = mdl_step(mb, b, ovl, 3, 32'b101, 3);
            mc = mdl_step(mc, b, ovl, 4, 32'b1101, 255);
        end
        check_all(tag);
    endtask

    task automatic send(input string tag, input logic [31:0] bits, input int n,
                        input logic ovl, input logic clr_last);
        logic [31:0] t;
        for (int i = n - 1; i >= 0; i--) begin
            t = bits >> i;
            cyc(tag, t[0], 1'b1, ovl, clr_last && (i == 0));
        end
    endtask

    // Reset raised between clock edges; outputs must clear before any edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk({tag, "_a_st"},  int'(a_st),  0);
        chk({tag, "_a_out"}, int'(a_out), 0);
        chk({tag, "_a_cnt"}, int'(a_cnt), 0);
        chk({tag, "_b_cnt"}, int'(b_cnt), 0);
        chk({tag, "_c_st"},  int'(c_st),  0);
        chk({tag, "_c_cnt"}, int'(c_cnt), 0);
        ma = mdl_clear();
        mb = mdl_clear();
        mc = mdl_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic b, v, ovl, clr;
        reset    = 1'b1;
        in       = 1'b0;
        in_valid = 1'b0;
        overlap  = 1'b0;
        clear    = 1'b0;
        ma = mdl_clear();
        mb = mdl_clear();
        mc = mdl_clear();
        #3;
        check_all("rst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Non-overlapping detection of 101.
        send("nov", 32'b1101011010110101, 16, 1'b0, 1'b0);
        chk("nov_a_final", int'(a_cnt), 3);
        cyc("clr1", 1'b0, 1'b0, 1'b0, 1'b1);

        // Overlapping detection of the same stream.
        send("ovl", 32'b1101011010110101, 16, 1'b1, 1'b0);
        chk("ovl_a_final", int'(a_cnt), 6);
        cyc("clr2", 1'b0, 1'b0, 1'b0, 1'b1);

        // Gaps with in_valid low: state must hold.
        for (int i = 2; i >= 0; i--) begin
            cyc("gap_bit", (i != 1), 1'b1, 1'b0, 1'b0);
            if (i != 0) begin
                cyc("gap_idle", 1'b1, 1'b0, 1'b1, 1'b0);
                cyc("gap_idle", 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end
        chk("gap_a_final", int'(a_cnt), 1);
        cyc("clr3", 1'b0, 1'b0, 1'b0, 1'b1);

        // Saturation of the 2-bit counter while detections continue.
        send("sat", 32'b1010101010, 10, 1'b1, 1'b0);
        chk("sat_b_final", int'(b_cnt), 3);
        chk("sat_a_final", int'(a_cnt), 4);
        cyc("clr4", 1'b0, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of a partial match.
        send("prst", 32'b10, 2, 1'b0, 1'b0);
        async_reset("arst");
        send("post", 32'b1, 1, 1'b0, 1'b0);
        chk("post_a_out", int'(a_out), 0);
        chk("post_a_cnt", int'(a_cnt), 0);
        cyc("clr5", 1'b0, 1'b0, 1'b0, 1'b1);

        // 1101 with overlap, then again with clear on the last bit.
        send("p4", 32'b1101101, 7, 1'b1, 1'b0);
        chk("p4_c_final", int'(c_cnt), 2);
        cyc("clr6", 1'b0, 1'b0, 1'b0, 1'b1);
        send("p4clr", 32'b1101101, 7, 1'b1, 1'b1);
        chk("p4clr_c_st", int'(c_st), 0);
        chk("p4clr_c_cnt", int'(c_cnt), 0);

        // Random traffic with occasional clears and resets.
        ovl = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            b   = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 15) == 0) ovl = ~ovl;
            if ($urandom_range(0, 499) == 0) async_reset("rnd_rst");
            cyc("rnd", b, v, ovl, clr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule
